// File: rtl/dac_pkg.sv
// Shared definitions for the DAC frame sequencer.
// Frame field widths, pad constant, sequencer states.
package dac_pkg;

    localparam int OP_W    = 4;
    localparam int ADDR_W  = 4;
    localparam int CODE_W  = 16;
    localparam int FRAME_W = 32;
    localparam int CMD_W   = OP_W + ADDR_W + CODE_W;
    localparam int PAD_W   = FRAME_W - CMD_W;

    localparam logic [PAD_W-1:0] FRAME_PAD = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_REQ,
        ST_XFER,
        ST_GAP
    } seq_state_t;

    // Build the SPI frame: zero pad, then {op, addr, code}
    function automatic logic [FRAME_W-1:0] make_frame(
        input logic [CMD_W-1:0] cmd
    );
        return {FRAME_PAD, cmd};
    endfunction

endpackage

// File: rtl/dac_cmd_fifo.sv
// Synchronous command FIFO with occupancy output.
// DEPTH must be a power of two so pointers wrap naturally.
module dac_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign dout    = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage array; contents need no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dac_frame_sequencer.sv
// Feeds queued DAC commands to the SPI engine as 32-bit frames.
// Tracks SYNCB per transfer, enforces a gap, flags start timeouts.
module dac_frame_sequencer
    import dac_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int MIN_GAP       = 8,
    parameter int START_TIMEOUT = 64
) (
    input  logic                          spi_clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [3:0]                    cmd_op,
    input  logic [3:0]                    cmd_addr,
    input  logic [15:0]                   cmd_data,
    output logic                          wr,
    output logic [31:0]                   data_spi_in,
    input  logic                          SYNCB,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   frames_sent,
    output logic                          err_timeout,
    input  logic                          err_clr
);

    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam int GW = $clog2(MIN_GAP + 1);

    seq_state_t       state_q;
    seq_state_t       state_d;

    logic             syncb_q1;
    logic             syncb_s;
    logic             syncb_prev;

    logic [CMD_W-1:0] fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;

    logic [TW-1:0]    tcnt_q;
    logic [GW-1:0]    gcnt_q;
    logic [15:0]      frames_q;
    logic [31:0]      frame_q;
    logic             err_q;

    logic             load_frame;
    logic             tmo_hit;
    logic             frame_done;

    dac_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (spi_clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .din   ({cmd_op, cmd_addr, cmd_data}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign cmd_ready   = !fifo_full;
    assign wr          = (state_q == ST_REQ);
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;
    assign data_spi_in = frame_q;
    assign frames_sent = frames_q;
    assign err_timeout = err_q;

    // Bring SYNCB into the spi_clk domain; idle level is high
    always_ff @(posedge spi_clk or negedge rst_n) begin
        if (!rst_n) begin
            syncb_q1   <= 1'b1;
            syncb_s    <= 1'b1;
            syncb_prev <= 1'b1;
        end else begin
            syncb_q1   <= SYNCB;
            syncb_s    <= syncb_q1;
            syncb_prev <= syncb_s;
        end
    end

    // Sequencer state register
    always_ff @(posedge spi_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state strobes
    always_comb begin
        state_d    = state_q;
        fifo_pop   = 1'b0;
        load_frame = 1'b0;
        tmo_hit    = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && syncb_s) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                fifo_pop   = 1'b1;
                load_frame = 1'b1;
                state_d    = ST_REQ;
            end
            ST_REQ: begin
                if (!syncb_s) begin
                    state_d = ST_XFER;
                end else if (tcnt_q == TW'(START_TIMEOUT - 1)) begin
                    tmo_hit = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_XFER: begin
                if (syncb_s && !syncb_prev) begin
                    frame_done = 1'b1;
                    state_d    = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gcnt_q == GW'(MIN_GAP - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Start-timeout and inter-frame gap counters
    always_ff @(posedge spi_clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
            gcnt_q <= '0;
        end else begin
            if (state_q == ST_REQ && state_d == ST_REQ) begin
                tcnt_q <= tcnt_q + TW'(1);
            end else begin
                tcnt_q <= '0;
            end
            if (state_q == ST_GAP && state_d == ST_GAP) begin
                gcnt_q <= gcnt_q + GW'(1);
            end else begin
                gcnt_q <= '0;
            end
        end
    end

    // Frame register, held until the next load
    always_ff @(posedge spi_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
        end else if (load_frame) begin
            frame_q <= make_frame(fifo_dout);
        end
    end

    // Completed-frame counter, wraps at 16 bits
    always_ff @(posedge spi_clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_q <= '0;
        end else if (frame_done) begin
            frames_q <= frames_q + 16'd1;
        end
    end

    // Sticky timeout flag; a new timeout beats a clear
    always_ff @(posedge spi_clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (tmo_hit) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Directed bench for dac_frame_sequencer.
// Engine behaviour is modelled by driving SYNCB.
module tb_dac_frame_sequencer;

    logic        spi_clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [3:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        wr;
    logic [31:0] data_spi_in;
    logic        SYNCB;
    logic        busy;
    logic [2:0]  fifo_level;
    logic [15:0] frames_sent;
    logic        err_timeout;
    logic        err_clr;

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;

    always #5 spi_clk = ~spi_clk;

    dac_frame_sequencer dut (
        .spi_clk     (spi_clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .wr          (wr),
        .data_spi_in (data_spi_in),
        .SYNCB       (SYNCB),
        .busy        (busy),
        .fifo_level  (fifo_level),
        .frames_sent (frames_sent),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    task automatic drive_cmd(input logic [23:0] c);
        {cmd_op, cmd_addr, cmd_data} = c;
        cmd_valid = 1'b1;
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(negedge spi_clk);
            n++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic serve(input int pre, output logic [31:0] f, output bit ok);
        int n = 0;
        f = '0;
        while (wr !== 1'b1 && n < 300) begin
            @(negedge spi_clk);
            n++;
        end
        ok = (wr === 1'b1);
        if (ok) begin
            f = data_spi_in;
            repeat (pre) @(negedge spi_clk);
            SYNCB = 1'b0;
            repeat (6) @(negedge spi_clk);
            SYNCB = 1'b1;
            repeat (4) @(negedge spi_clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        SYNCB = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_addr = '0;
        cmd_data = '0;
        err_clr = 1'b0;
        repeat (3) @(negedge spi_clk);
        checks++;
        if (wr !== 1'b0) begin
            errors++; $display("FAIL reset_wr: got %b want 0", wr);
        end
        checks++;
        if (data_spi_in !== 32'h0) begin
            errors++; $display("FAIL reset_data: got %h want 0", data_spi_in);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready);
        end
        checks++;
        if (busy !== 1'b0 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL reset_busy_level: got %b/%0d want 0/0", busy, fifo_level);
        end
        checks++;
        if (frames_sent !== 16'h0 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt_err: got %h/%b want 0/0", frames_sent, err_timeout);
        end
        rst_n = 1'b1;
        @(negedge spi_clk);
    endtask

    task automatic test_single;
        drive_cmd({4'h3, 4'h2, 16'hABCD});
        @(posedge spi_clk);
        #1 cmd_valid = 1'b0;
        @(negedge spi_clk);
        checks++;
        if (wr !== 1'b0 || fifo_level !== 3'd1) begin
            errors++; $display("FAIL single_e1: wr/level got %b/%0d want 0/1", wr, fifo_level);
        end
        @(negedge spi_clk);
        checks++;
        if (wr !== 1'b0) begin
            errors++; $display("FAIL single_e2: wr got %b want 0", wr);
        end
        @(negedge spi_clk);
        checks++;
        if (wr !== 1'b1 || data_spi_in !== 32'h0032ABCD) begin
            errors++;
            $display("FAIL single_e3: wr/data got %b/%h want 1/0032abcd", wr, data_spi_in);
        end
        repeat (20) @(negedge spi_clk);
        SYNCB = 1'b0;
        repeat (2) @(negedge spi_clk);
        checks++;
        if (wr !== 1'b1) begin
            errors++; $display("FAIL single_wr_hold: got %b want 1", wr);
        end
        @(negedge spi_clk);
        checks++;
        if (wr !== 1'b0 || data_spi_in !== 32'h0032ABCD) begin
            errors++;
            $display("FAIL single_wr_drop: wr/data got %b/%h want 0/0032abcd", wr, data_spi_in);
        end
        repeat (5) @(negedge spi_clk);
        SYNCB = 1'b1;
        repeat (2) @(negedge spi_clk);
        checks++;
        if (frames_sent !== 16'd0) begin
            errors++; $display("FAIL single_cnt_early: got %0d want 0", frames_sent);
        end
        @(negedge spi_clk);
        checks++;
        if (frames_sent !== 16'd1) begin
            errors++; $display("FAIL single_cnt: got %0d want 1", frames_sent);
        end
        exp_frames = 1;
        repeat (7) @(negedge spi_clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL single_gap_busy: got %b want 1", busy);
        end
        @(negedge spi_clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL single_idle: busy got %b want 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [23:0] cmds [5];
        logic [31:0] exp  [5];
        logic [31:0] f;
        bit ok;
        cmds = '{24'h1F0001, 24'h2E1234, 24'h3DFFFF, 24'h4C8000, 24'h5B00FF};
        exp  = '{32'h001F0001, 32'h002E1234, 32'h003DFFFF, 32'h004C8000, 32'h005B00FF};
        for (int i = 0; i < 5; i++) begin
            drive_cmd(cmds[i]);
            checks++;
            if (cmd_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_ready_%0d: got %b want 1", i, cmd_ready);
            end
            @(negedge spi_clk);
        end
        checks++;
        if (cmd_ready !== 1'b0 || fifo_level !== 3'd4) begin
            errors++;
            $display("FAIL b2b_full: ready/level got %b/%0d want 0/4", cmd_ready, fifo_level);
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            serve(3, f, ok);
            checks++;
            if (!ok || f !== exp[i]) begin
                errors++;
                $display("FAIL b2b_frame_%0d: got %h ok=%b want %h", i, f, ok, exp[i]);
            end
        end
        exp_frames += 5;
        checks++;
        if (frames_sent !== 16'(exp_frames)) begin
            errors++; $display("FAIL b2b_cnt: got %0d want %0d", frames_sent, exp_frames);
        end
    endtask

    task automatic test_timeout;
        int n;
        int hi;
        bit ok;
        wait_idle(ok);
        drive_cmd({4'h7, 4'h1, 16'h0F0F});
        @(posedge spi_clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        while (wr !== 1'b1 && n < 20) begin
            @(negedge spi_clk);
            n++;
        end
        hi = 0;
        while (wr === 1'b1 && hi < 200) begin
            hi++;
            @(negedge spi_clk);
        end
        checks++;
        if (hi != 64) begin
            errors++; $display("FAIL tmo_wr_len: got %0d want 64", hi);
        end
        checks++;
        if (err_timeout !== 1'b1 || frames_sent !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL tmo_flag: err/cnt got %b/%0d want 1/%0d",
                     err_timeout, frames_sent, exp_frames);
        end
        err_clr = 1'b1;
        @(negedge spi_clk);
        err_clr = 1'b0;
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++; $display("FAIL tmo_clr: got %b want 0", err_timeout);
        end
        wait_idle(ok);
        err_clr = 1'b1;
        drive_cmd({4'h7, 4'h2, 16'h0F0F});
        @(posedge spi_clk);
        #1 cmd_valid = 1'b0;
        n = 0;
        while (wr !== 1'b1 && n < 20) begin
            @(negedge spi_clk);
            n++;
        end
        n = 0;
        while (wr === 1'b1 && n < 200) begin
            @(negedge spi_clk);
            n++;
        end
        checks++;
        if (err_timeout !== 1'b1) begin
            errors++; $display("FAIL tmo_set_wins: got %b want 1", err_timeout);
        end
        @(negedge spi_clk);
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++; $display("FAIL tmo_clr_after: got %b want 0", err_timeout);
        end
        err_clr = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL tmo_idle: busy got %b want 0", busy);
        end
    endtask

    task automatic test_stream;
        logic [31:0] exp [3];
        logic [31:0] f;
        bit ok;
        exp = '{32'h00A10001, 32'h00B20002, 32'h00C30003};
        drive_cmd(24'hA10001);
        @(negedge spi_clk);
        drive_cmd(24'hB20002);
        @(negedge spi_clk);
        checks++;
        if (fifo_level !== 3'd2) begin
            errors++; $display("FAIL stream_lvl_pre: got %0d want 2", fifo_level);
        end
        drive_cmd(24'hC30003);
        @(negedge spi_clk);
        cmd_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd2 || wr !== 1'b1) begin
            errors++;
            $display("FAIL stream_lvl_same: level/wr got %0d/%b want 2/1", fifo_level, wr);
        end
        for (int i = 0; i < 3; i++) begin
            serve(2, f, ok);
            checks++;
            if (!ok || f !== exp[i]) begin
                errors++;
                $display("FAIL stream_frame_%0d: got %h ok=%b want %h", i, f, ok, exp[i]);
            end
        end
        exp_frames += 3;
        checks++;
        if (frames_sent !== 16'(exp_frames)) begin
            errors++; $display("FAIL stream_cnt: got %0d want %0d", frames_sent, exp_frames);
        end
    endtask

    task automatic test_reset_mid;
        int hi;
        bit ok;
        wait_idle(ok);
        drive_cmd(24'h111111);
        @(negedge spi_clk);
        drive_cmd(24'h222222);
        @(negedge spi_clk);
        drive_cmd(24'h333333);
        @(negedge spi_clk);
        cmd_valid = 1'b0;
        SYNCB = 1'b0;
        repeat (4) @(negedge spi_clk);
        checks++;
        if (wr !== 1'b0 || fifo_level !== 3'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: wr/level/busy got %b/%0d/%b want 0/2/1",
                     wr, fifo_level, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (wr !== 1'b0 || fifo_level !== 3'd0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_async: wr/level/busy/ready got %b/%0d/%b/%b want 0/0/0/1",
                     wr, fifo_level, busy, cmd_ready);
        end
        repeat (2) @(negedge spi_clk);
        SYNCB = 1'b1;
        rst_n = 1'b1;
        exp_frames = 0;
        hi = 0;
        repeat (30) begin
            @(negedge spi_clk);
            if (wr === 1'b1) hi++;
        end
        checks++;
        if (hi != 0 || frames_sent !== 16'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_stale: wr_cycles/cnt/busy got %0d/%0d/%b want 0/0/0",
                     hi, frames_sent, busy);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] f;
        bit ok;
        force dut.frames_q = 16'hFFFF;
        @(negedge spi_clk);
        release dut.frames_q;
        @(negedge spi_clk);
        checks++;
        if (frames_sent !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_preload: got %h want ffff", frames_sent);
        end
        drive_cmd(24'h9D5A5A);
        @(posedge spi_clk);
        #1 cmd_valid = 1'b0;
        @(negedge spi_clk);
        serve(1, f, ok);
        checks++;
        if (!ok || f !== 32'h009D5A5A) begin
            errors++; $display("FAIL wrap_frame: got %h ok=%b want 009d5a5a", f, ok);
        end
        checks++;
        if (frames_sent !== 16'h0000) begin
            errors++; $display("FAIL wrap_cnt: got %h want 0000", frames_sent);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_stream();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
